// File: rtl/mem_access_if.sv
// Request/response handshake and main-memory bus between the load/store stage and mem_access_unit.
// The pipeline/bench side uses modport master; mem_access_unit uses modport slave.
interface mem_access_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;

    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_read_write;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_error,
        input  mem_address, mem_data_in, mem_read_write,
        output mem_data_out
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_error,
        output mem_address, mem_data_in, mem_read_write,
        input  mem_data_out
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store engine driving a word-wide little-endian main memory.
// Sub-word stores are done as read-modify-write; one request in flight at a time.
module mem_access_unit #(
    parameter logic [31:0] BASE_ADDR       = 32'h0100_0000,
    parameter logic [31:0] MEM_DEPTH_BYTES = 32'h0010_0000
) (
    input  logic         clock,
    input  logic         reset,
    mem_access_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    // 33-bit bounds so BASE_ADDR+MEM_DEPTH_BYTES cannot wrap
    localparam logic [32:0] ADDR_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] ADDR_HI = {1'b0, BASE_ADDR} + {1'b0, MEM_DEPTH_BYTES} - 33'd4;

    logic [1:0]  state_reg;
    logic        write_reg;
    logic [1:0]  size_reg;
    logic        unsigned_reg;
    logic [1:0]  offset_reg;
    logic [15:0] wdata_reg;
    logic [31:0] wr_word_reg;
    logic [31:0] rdata_reg;
    logic        error_reg;
    logic [31:0] mem_address_reg;

    logic        accept;
    logic        req_error;
    logic        size_bad;
    logic        misaligned;
    logic        out_of_range;
    logic [3:0]  lane_hit;
    logic [31:0] merged_word;
    logic [31:0] load_value;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    assign accept = bus.req_valid && (state_reg == ST_IDLE);

    assign size_bad     = (bus.req_size == SZ_BAD);
    assign misaligned   = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                          ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
    assign out_of_range = ({1'b0, bus.req_addr} < ADDR_LO) ||
                          ({1'b0, bus.req_addr} > ADDR_HI);
    assign req_error    = size_bad || misaligned || out_of_range;

    // Per-lane merge of store data into the word read back from memory
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_hit[gi] = ((size_reg == SZ_BYTE) && (offset_reg == 2'(gi))) ||
                                  ((size_reg == SZ_HALF) && (offset_reg[1] == 1'(gi / 2)));
            if ((gi % 2) == 0) begin : g_even
                assign merged_word[8*gi +: 8] = lane_hit[gi] ? wdata_reg[7:0]
                                                             : bus.mem_data_out[8*gi +: 8];
            end else begin : g_odd
                assign merged_word[8*gi +: 8] = lane_hit[gi]
                    ? ((size_reg == SZ_BYTE) ? wdata_reg[7:0] : wdata_reg[15:8])
                    : bus.mem_data_out[8*gi +: 8];
            end
        end
    endgenerate

    assign load_byte = bus.mem_data_out[{offset_reg, 3'b000} +: 8];
    assign load_half = offset_reg[1] ? bus.mem_data_out[31:16] : bus.mem_data_out[15:0];

    always_comb begin
        load_value = bus.mem_data_out;
        case (size_reg)
            SZ_BYTE: load_value = unsigned_reg ? {24'd0, load_byte}
                                               : {{24{load_byte[7]}}, load_byte};
            SZ_HALF: load_value = unsigned_reg ? {16'd0, load_half}
                                               : {{16{load_half[15]}}, load_half};
            default: load_value = bus.mem_data_out;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            write_reg       <= 1'b0;
            size_reg        <= 2'b00;
            unsigned_reg    <= 1'b0;
            offset_reg      <= 2'b00;
            wdata_reg       <= 16'd0;
            wr_word_reg     <= 32'd0;
            rdata_reg       <= 32'd0;
            error_reg       <= 1'b0;
            mem_address_reg <= BASE_ADDR;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        write_reg    <= bus.req_write;
                        size_reg     <= bus.req_size;
                        unsigned_reg <= bus.req_unsigned;
                        offset_reg   <= bus.req_addr[1:0];
                        wdata_reg    <= bus.req_wdata[15:0];
                        rdata_reg    <= 32'd0;
                        error_reg    <= req_error;
                        if (req_error) begin
                            state_reg <= ST_RESP;
                        end else begin
                            mem_address_reg <= {bus.req_addr[31:2], 2'b00};
                            if (bus.req_write && (bus.req_size == SZ_WORD)) begin
                                wr_word_reg <= bus.req_wdata;
                                state_reg   <= ST_WRITE;
                            end else begin
                                state_reg   <= ST_READ;
                            end
                        end
                    end
                end
                ST_READ: begin
                    if (write_reg) begin
                        wr_word_reg <= merged_word;
                        state_reg   <= ST_WRITE;
                    end else begin
                        rdata_reg   <= load_value;
                        state_reg   <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    state_reg <= ST_RESP;
                end
                default: begin
                    rdata_reg <= 32'd0;
                    error_reg <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready      = (state_reg == ST_IDLE);
    assign bus.resp_valid     = (state_reg == ST_RESP);
    assign bus.resp_rdata     = (state_reg == ST_RESP) ? rdata_reg : 32'd0;
    assign bus.resp_error     = (state_reg == ST_RESP) ? error_reg : 1'b0;
    assign bus.mem_address    = mem_address_reg;
    // Reset suppresses a write that would otherwise commit on this edge
    assign bus.mem_read_write = (state_reg == ST_WRITE) && !reset;
    assign bus.mem_data_in    = (state_reg == ST_WRITE) ? wr_word_reg : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver queues expected responses/writes,
// a negedge monitor pops and compares them whenever the DUT responds or writes memory.
module tb_mem_access_unit;
    localparam logic [31:0] BASE = 32'h0100_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_if bus();

    mem_access_unit #(
        .BASE_ADDR       (BASE),
        .MEM_DEPTH_BYTES (32'h0010_0000)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    // Small main-memory model: combinational read, write on posedge
    logic [31:0] mem_words [0:255];
    assign bus.mem_data_out = mem_words[bus.mem_address[9:2]];
    always @(posedge clk) begin
        if (bus.mem_read_write) mem_words[bus.mem_address[9:2]] = bus.mem_data_in;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        string       name;
    } resp_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        string       name;
    } wr_t;

    resp_t resp_q[$];
    wr_t   wr_q[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor
    always @(negedge clk) begin : monitor
        resp_t e;
        wr_t   w;
        if (bus.resp_valid) begin
            if (resp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_resp: got rdata=0x%08h err=%0b, expected no response",
                         bus.resp_rdata, bus.resp_error);
            end else begin
                e = resp_q.pop_front();
                $display("[TB] resp %-14s rdata=0x%08h err=%0b cyc=%0d", e.name,
                         bus.resp_rdata, bus.resp_error, cyc);
                check({e.name, "_rdata"}, bus.resp_rdata, e.rdata);
                check({e.name, "_error"}, 32'(bus.resp_error), 32'(e.err));
                check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
                check({e.name, "_ready_low"}, 32'(bus.req_ready), 32'd0);
            end
        end
        if (bus.mem_read_write) begin
            if (wr_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_write: got addr=0x%08h data=0x%08h, expected no write",
                         bus.mem_address, bus.mem_data_in);
            end else begin
                w = wr_q.pop_front();
                $display("[TB] write %-13s addr=0x%08h data=0x%08h", w.name,
                         bus.mem_address, bus.mem_data_in);
                check({w.name, "_waddr"}, bus.mem_address, w.addr);
                check({w.name, "_wdata"}, bus.mem_data_in, w.data);
                check({w.name, "_wready_low"}, 32'(bus.req_ready), 32'd0);
            end
        end
    end

    // Called at a negedge; leaves req_valid high so consecutive calls are back-to-back
    task automatic issue(input string name, input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input int lat,
                         input logic exp_wr, input logic [31:0] exp_wd);
        int waited = 0;
        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = u;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        while (!bus.req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s_accept_timeout: got req_ready=0, expected 1 within 20 cycles", name);
            return;
        end
        resp_q.push_back('{exp_rd, exp_err, cyc + lat, name});
        if (exp_wr) wr_q.push_back('{{a[31:2], 2'b00}, exp_wd, name});
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  32'(bus.req_ready), 32'd1);
        check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, "_resp_rdata"}, bus.resp_rdata, 32'd0);
        check({tag, "_resp_error"}, 32'(bus.resp_error), 32'd0);
        check({tag, "_mem_address"}, bus.mem_address, BASE);
        check({tag, "_mem_data_in"}, bus.mem_data_in, 32'd0);
        check({tag, "_mem_rw"}, 32'(bus.mem_read_write), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_words[i] = 32'd0;
        mem_words[0]   = 32'h8bad_f00d;
        mem_words[255] = 32'hcafe_babe;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_reset");

        //    name          w     sz     u     addr           wdata          exp_rdata      err  lat wr    exp_wdata
        issue("lb_03",      1'b0, 2'b00, 1'b0, 32'h0100_0003, 32'h0,        32'hFFFF_FF8B, 1'b0, 2, 1'b0, 32'h0);
        issue("lbu_03",     1'b0, 2'b00, 1'b1, 32'h0100_0003, 32'h0,        32'h0000_008B, 1'b0, 2, 1'b0, 32'h0);
        issue("lh_02",      1'b0, 2'b01, 1'b0, 32'h0100_0002, 32'h0,        32'hFFFF_8BAD, 1'b0, 2, 1'b0, 32'h0);
        issue("lhu_02",     1'b0, 2'b01, 1'b1, 32'h0100_0002, 32'h0,        32'h0000_8BAD, 1'b0, 2, 1'b0, 32'h0);
        issue("lbu_01",     1'b0, 2'b00, 1'b1, 32'h0100_0001, 32'h0,        32'h0000_00F0, 1'b0, 2, 1'b0, 32'h0);
        issue("lh_00",      1'b0, 2'b01, 1'b0, 32'h0100_0000, 32'h0,        32'hFFFF_F00D, 1'b0, 2, 1'b0, 32'h0);
        issue("sb_01",      1'b1, 2'b00, 1'b0, 32'h0100_0001, 32'h1234_5655, 32'h0,        1'b0, 3, 1'b1, 32'h8bad_550d);
        issue("lw_00",      1'b0, 2'b10, 1'b0, 32'h0100_0000, 32'h0,        32'h8bad_550d, 1'b0, 2, 1'b0, 32'h0);
        issue("sw_04",      1'b1, 2'b10, 1'b0, 32'h0100_0004, 32'h1234_5678, 32'h0,        1'b0, 2, 1'b1, 32'h1234_5678);
        issue("lw_04",      1'b0, 2'b10, 1'b0, 32'h0100_0004, 32'h0,        32'h1234_5678, 1'b0, 2, 1'b0, 32'h0);
        issue("sh_06",      1'b1, 2'b01, 1'b0, 32'h0100_0006, 32'hDEAD_BEEF, 32'h0,        1'b0, 3, 1'b1, 32'hBEEF_5678);
        issue("lw_04b",     1'b0, 2'b10, 1'b0, 32'h0100_0004, 32'h0,        32'hBEEF_5678, 1'b0, 2, 1'b0, 32'h0);
        issue("lw_top",     1'b0, 2'b10, 1'b0, 32'h010F_FFFC, 32'h0,        32'hCAFE_BABE, 1'b0, 2, 1'b0, 32'h0);
        issue("err_half",   1'b0, 2'b01, 1'b0, 32'h0100_0001, 32'h0,        32'h0,         1'b1, 1, 1'b0, 32'h0);
        issue("err_word",   1'b1, 2'b10, 1'b0, 32'h0100_0002, 32'hFFFF_FFFF, 32'h0,        1'b1, 1, 1'b0, 32'h0);
        issue("err_low",    1'b0, 2'b10, 1'b0, 32'h00FF_FFFC, 32'h0,        32'h0,         1'b1, 1, 1'b0, 32'h0);
        issue("err_high",   1'b1, 2'b10, 1'b0, 32'h0110_0000, 32'h1111_1111, 32'h0,        1'b1, 1, 1'b0, 32'h0);
        issue("err_size",   1'b0, 2'b11, 1'b0, 32'h0100_0000, 32'h0,        32'h0,         1'b1, 1, 1'b0, 32'h0);
        issue("err_top_b",  1'b1, 2'b00, 1'b0, 32'h010F_FFFD, 32'h0000_0077, 32'h0,        1'b1, 1, 1'b0, 32'h0);
        bus.req_valid = 1'b0;

        for (int i = 0; i < 50 && (resp_q.size() != 0 || wr_q.size() != 0); i++) @(negedge clk);
        check("drain_resp_q", 32'(resp_q.size()), 32'd0);
        check("drain_wr_q", 32'(wr_q.size()), 32'd0);
        check("mem_word1", mem_words[1], 32'hBEEF_5678);
        repeat (2) @(negedge clk);

        // Reset during the WRITE cycle of a byte store: write and response both dropped
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size  = 2'b00;
        bus.req_addr  = BASE;
        bus.req_wdata = 32'h0000_00AA;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_wr_merged", bus.mem_data_in, 32'h8bad_55aa);
        check("rst_wr_gated", 32'(bus.mem_read_write), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("after_rst");
        check("rst_mem_word0", mem_words[0], 32'h8bad_550d);
        repeat (4) @(negedge clk);
        check("rst_ready_idle", 32'(bus.req_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
